// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg -- shared definitions for the RAM arbiter and its neighbours.
//
// Contents:
//   ADDR_W / DATA_W   : word-address and data widths of the 512x32 RAM.
//   arb_state_e       : arbiter FSM states (IDLE -> ACCESS -> RESP).
//   REQ_ID0 / REQ_ID1 : requester identifiers (CPU path, loader/debug port).
//   rr_pick()         : round-robin winner selection helper.
//
// Optional feature macro: RAM_ARB_RR_EN (consumed by ram_arbiter).
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Pick a winner from two eligible flags. On contention the requester that
  // was not served last wins; otherwise whichever one is eligible wins.
  // Only meaningful when at least one flag is set.
  function automatic logic rr_pick(input logic elig0, input logic elig1,
                                   input logic last_served);
    logic pick;
    if (elig0 && elig1) begin
      pick = ~last_served;
    end else if (elig0) begin
      pick = REQ_ID0;
    end else begin
      pick = REQ_ID1;
    end
    return pick;
  endfunction

endpackage : mem_pkg

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter -- two-requester arbiter in front of a 512x32 synchronous RAM.
//
// Every access takes three cycles: IDLE (grant, drive RAM strobes) ->
// ACCESS (strobes drop, RAM samples) -> RESP (RAM data valid, ack pulse and
// rdata capture on the following edge). All outputs are registered.
//
// Ports:
//   clk               in   system clock, rising-edge
//   rst_n             in   asynchronous active-low reset
//   req0 / req1       in   access request (0 = CPU MAR/MDR, 1 = loader/debug)
//   wr0 / wr1         in   1 = write, 0 = read (stable until ack)
//   addr0 / addr1     in   word address (stable until ack)
//   wdata0 / wdata1   in   write data (stable until ack)
//   ack0 / ack1       out  one-cycle completion pulse
//   rdata             out  read data, valid while ackN is high after a read
//   busy              out  high whenever the FSM is not in IDLE
//   ram_read          out  registered RAM read strobe
//   ram_write         out  registered RAM write strobe
//   ram_addr          out  registered RAM address
//   ram_din           out  registered RAM write data
//   ram_dout          in   RAM read data, valid the cycle after ram_read
//
// Configuration macro:
//   RAM_ARB_RR_EN  defined   -> round-robin arbitration with a 1-bit
//                               last-served pointer.
//                  undefined -> requester 0 has fixed priority.
// -----------------------------------------------------------------------------
module ram_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              is_read_q, is_read_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
`ifdef RAM_ARB_RR_EN
  logic              last_q, last_d;
`endif

  logic elig0_s;
  logic elig1_s;
  logic gnt_valid_s;
  logic gnt_id_s;

  // A requester is masked in the cycle its ack is high, so a req still held
  // from the finished access cannot be granted a second time.
  assign elig0_s = req0 & ~ack0_q;
  assign elig1_s = req1 & ~ack1_q;

  // Arbitration: pick which eligible requester, if any, is granted from IDLE.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = REQ_ID0;
`ifdef RAM_ARB_RR_EN
    gnt_valid_s = elig0_s | elig1_s;
    gnt_id_s    = rr_pick(elig0_s, elig1_s, last_q);
`else
    // Requester 0 keeps priority even during its own (masked) ack cycle, so
    // a continuously held req0 is never interleaved by requester 1.
    if (elig0_s) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = REQ_ID0;
    end else if (elig1_s && !req0) begin
      gnt_valid_s = 1'b1;
      gnt_id_s    = REQ_ID1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_id_s    = REQ_ID0;
    end
`endif
  end

  // Next-state and registered-output logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    is_read_d   = is_read_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata_d     = rdata_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
`ifdef RAM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          owner_d = gnt_id_s;
          if (gnt_id_s == REQ_ID1) begin
            ram_addr_d  = addr1;
            ram_din_d   = wdata1;
            ram_write_d = wr1;
            ram_read_d  = ~wr1;
            is_read_d   = ~wr1;
          end else begin
            ram_addr_d  = addr0;
            ram_din_d   = wdata0;
            ram_write_d = wr0;
            ram_read_d  = ~wr0;
            is_read_d   = ~wr0;
          end
`ifdef RAM_ARB_RR_EN
          last_d  = gnt_id_s;
`endif
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        // Strobes fall back to their 1'b0 defaults; RAM samples at this edge.
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (owner_q == REQ_ID1) begin
          ack1_d = 1'b1;
        end else begin
          ack0_d = 1'b1;
        end
        if (is_read_q) begin
          rdata_d = ram_dout;
        end else begin
          rdata_d = rdata_q;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_ID0;
      is_read_q   <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_din_q   <= {DATA_W{1'b0}};
`ifdef RAM_ARB_RR_EN
      // "Last served = 1" makes requester 0 win the first contention.
      last_q      <= REQ_ID1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      is_read_q   <= is_read_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
`ifdef RAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter -- directed self-checking bench for ram_arbiter with a
// behavioural 512x32 synchronous RAM. Expectations follow the RAM_ARB_RR_EN
// setting of the build.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, busy, ram_read, ram_write;
  logic [31:0] rdata, ram_din, ram_dout;
  logic [8:0]  ram_addr;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;

  logic [31:0] mem [0:511];
  logic        ram_init_done = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .busy      (busy),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Synchronous RAM model, preloaded on its first clock edge.
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[5]        <= 32'hDEADBEEF;
      ram_dout      <= 32'h0;
      ram_init_done <= 1'b1;
    end else begin
      if (ram_write) mem[ram_addr] <= ram_din;
      if (ram_read)  ram_dout <= mem[ram_addr];
    end
  end

  // Strobe monitor: counts write strobes and any read+write overlap.
  always @(posedge clk) begin
    if (ram_write === 1'b1) wr_cnt <= wr_cnt + 1;
    if (ram_read === 1'b1 && ram_write === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 9'h0; addr1 = 9'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (ack0 !== 1'b0) begin miss_cnt++; $display("FAIL reset_ack0 got %b exp 0", ack0); end
    vec_cnt++; if (ack1 !== 1'b0) begin miss_cnt++; $display("FAIL reset_ack1 got %b exp 0", ack1); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec_cnt++; if (ram_read !== 1'b0 || ram_write !== 1'b0) begin miss_cnt++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0/0", ram_read, ram_write); end
    vec_cnt++; if (ram_addr !== 9'h0) begin miss_cnt++; $display("FAIL reset_addr got %h exp 000", ram_addr); end
    vec_cnt++; if (ram_din !== 32'h0) begin miss_cnt++; $display("FAIL reset_din got %h exp 0", ram_din); end
    vec_cnt++; if (rdata !== 32'h0) begin miss_cnt++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_read();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h005;
    tick(); // E0
    vec_cnt++; if (ram_read !== 1'b1 || ram_write !== 1'b0) begin miss_cnt++; $display("FAIL read_e0_strobes got rd=%b wr=%b exp 1/0", ram_read, ram_write); end
    vec_cnt++; if (ram_addr !== 9'h005) begin miss_cnt++; $display("FAIL read_e0_addr got %h exp 005", ram_addr); end
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL read_e0_busy got %b exp 1", busy); end
    tick(); // E1
    vec_cnt++; if (ram_read !== 1'b0 || busy !== 1'b1 || ack0 !== 1'b0) begin miss_cnt++; $display("FAIL read_e1 got rd=%b busy=%b ack0=%b exp 0/1/0", ram_read, busy, ack0); end
    tick(); // E2
    vec_cnt++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin miss_cnt++; $display("FAIL read_e2_ack got ack0=%b ack1=%b exp 1/0", ack0, ack1); end
    vec_cnt++; if (rdata !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL read_e2_rdata got %h exp deadbeef", rdata); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL read_e2_busy got %b exp 0", busy); end
    req0 = 1'b0;
    tick(); // E3
    vec_cnt++; if (ack0 !== 1'b0 || busy !== 1'b0 || ram_read !== 1'b0) begin miss_cnt++; $display("FAIL read_e3_idle got ack0=%b busy=%b rd=%b exp 0/0/0", ack0, busy, ram_read); end
    vec_cnt++; if (rdata !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL read_e3_hold got %h exp deadbeef", rdata); end
  endtask

  task automatic test_write_then_read();
    int wc0;
    wc0 = wr_cnt;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 9'h1FF; wdata1 = 32'h12345678;
    tick(); // E0
    vec_cnt++; if (ram_write !== 1'b1 || ram_read !== 1'b0) begin miss_cnt++; $display("FAIL wr_e0_strobes got rd=%b wr=%b exp 0/1", ram_read, ram_write); end
    vec_cnt++; if (ram_addr !== 9'h1FF || ram_din !== 32'h12345678) begin miss_cnt++; $display("FAIL wr_e0_bus got addr=%h din=%h exp 1ff/12345678", ram_addr, ram_din); end
    tick(); // E1
    vec_cnt++; if (ram_write !== 1'b0) begin miss_cnt++; $display("FAIL wr_e1_strobe got %b exp 0", ram_write); end
    tick(); // E2
    vec_cnt++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin miss_cnt++; $display("FAIL wr_e2_ack got ack0=%b ack1=%b exp 0/1", ack0, ack1); end
    vec_cnt++; if (rdata !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL wr_rdata_hold got %h exp deadbeef", rdata); end
    req1 = 1'b0;
    tick(); // E3
    vec_cnt++; if (ack1 !== 1'b0) begin miss_cnt++; $display("FAIL wr_e3_ack got %b exp 0", ack1); end
    req1 = 1'b1; wr1 = 1'b0;
    tick(); // read E0
    vec_cnt++; if (ram_read !== 1'b1 || ram_addr !== 9'h1FF) begin miss_cnt++; $display("FAIL rd1_e0 got rd=%b addr=%h exp 1/1ff", ram_read, ram_addr); end
    tick();
    tick(); // read E2
    vec_cnt++; if (ack1 !== 1'b1 || rdata !== 32'h12345678) begin miss_cnt++; $display("FAIL rd1_e2 got ack1=%b rdata=%h exp 1/12345678", ack1, rdata); end
    req1 = 1'b0;
    tick();
    vec_cnt++; if (wr_cnt - wc0 !== 1) begin miss_cnt++; $display("FAIL wr_strobe_count got %0d exp 1", wr_cnt - wc0); end
  endtask

  task automatic test_contention();
    int n, a0, a1, exp_n, exp_a0, exp_a1;
    logic g [0:7];
    logic eg [0:7];
    n = 0; a0 = 0; a1 = 0;
    for (int i = 0; i < 8; i++) begin g[i] = 1'b0; eg[i] = 1'b0; end
`ifdef RAM_ARB_RR_EN
    exp_n = 4; exp_a0 = 2; exp_a1 = 2;
    eg[1] = 1'b1; eg[3] = 1'b1;
`else
    exp_n = 3; exp_a0 = 3; exp_a1 = 0;
`endif
    req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h005;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h1FF;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ram_read === 1'b1 && n < 8) begin
        g[n] = (ram_addr == 9'h1FF);
        n++;
      end
      if (ack0 === 1'b1) a0++;
      if (ack1 === 1'b1) a1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    vec_cnt++; if (n !== exp_n) begin miss_cnt++; $display("FAIL cont_grants got %0d exp %0d", n, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      vec_cnt++; if (g[i] !== eg[i]) begin miss_cnt++; $display("FAIL cont_order[%0d] got req%0d exp req%0d", i, g[i], eg[i]); end
    end
    vec_cnt++; if (a0 !== exp_a0 || a1 !== exp_a1) begin miss_cnt++; $display("FAIL cont_acks got %0d/%0d exp %0d/%0d", a0, a1, exp_a0, exp_a1); end
    repeat (3) tick();
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL cont_settle_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_abort();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 9'h010; wdata0 = 32'hA5A5A5A5;
    tick(); // E0 -> ACCESS
    vec_cnt++; if (ram_write !== 1'b1 || busy !== 1'b1) begin miss_cnt++; $display("FAIL abort_e0 got wr=%b busy=%b exp 1/1", ram_write, busy); end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++; if (ram_write !== 1'b0 || ram_read !== 1'b0) begin miss_cnt++; $display("FAIL abort_strobes got rd=%b wr=%b exp 0/0", ram_read, ram_write); end
    vec_cnt++; if (busy !== 1'b0 || ack0 !== 1'b0) begin miss_cnt++; $display("FAIL abort_state got busy=%b ack0=%b exp 0/0", busy, ack0); end
    vec_cnt++; if (ram_addr !== 9'h0 || ram_din !== 32'h0 || rdata !== 32'h0) begin miss_cnt++; $display("FAIL abort_regs got addr=%h din=%h rdata=%h exp 0/0/0", ram_addr, ram_din, rdata); end
    #1 rst_n = 1'b1;
    tick(); // re-issued E0
    vec_cnt++; if (ram_write !== 1'b1 || ram_addr !== 9'h010) begin miss_cnt++; $display("FAIL reissue_e0 got wr=%b addr=%h exp 1/010", ram_write, ram_addr); end
    tick(); // original access would have acked here
    vec_cnt++; if (ack0 !== 1'b0 || ram_write !== 1'b0) begin miss_cnt++; $display("FAIL reissue_e1 got ack0=%b wr=%b exp 0/0", ack0, ram_write); end
    tick();
    vec_cnt++; if (ack0 !== 1'b1) begin miss_cnt++; $display("FAIL reissue_ack got %b exp 1", ack0); end
    req0 = 1'b0; wr0 = 1'b0;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 9'h010;
    tick(); tick(); tick();
    vec_cnt++; if (ack1 !== 1'b1 || rdata !== 32'hA5A5A5A5) begin miss_cnt++; $display("FAIL reissue_readback got ack1=%b rdata=%h exp 1/a5a5a5a5", ack1, rdata); end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_hold_through_ack();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 9'h005;
    tick(); // E0
    vec_cnt++; if (ram_read !== 1'b1) begin miss_cnt++; $display("FAIL hold_e0 got rd=%b exp 1", ram_read); end
    tick();
    tick(); // E2
    vec_cnt++; if (ack0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin miss_cnt++; $display("FAIL hold_e2 got ack0=%b rdata=%h exp 1/deadbeef", ack0, rdata); end
    tick(); // E3: held req0 must not be re-granted in its ack cycle
    vec_cnt++; if (ram_read !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0) begin miss_cnt++; $display("FAIL hold_e3_nogrant got rd=%b busy=%b ack0=%b exp 0/0/0", ram_read, busy, ack0); end
    tick(); // E4: still held, new grant
    vec_cnt++; if (ram_read !== 1'b1 || ram_addr !== 9'h005) begin miss_cnt++; $display("FAIL hold_e4_regrant got rd=%b addr=%h exp 1/005", ram_read, ram_addr); end
    req0 = 1'b0;
    tick();
    tick(); // E6
    vec_cnt++; if (ack0 !== 1'b1) begin miss_cnt++; $display("FAIL hold_e6_ack got %b exp 1", ack0); end
    tick(); // E7
    vec_cnt++; if (ram_read !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0) begin miss_cnt++; $display("FAIL hold_e7_idle got rd=%b busy=%b ack0=%b exp 0/0/0", ram_read, busy, ack0); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_read();
    test_contention();
    test_reset_abort();
    test_hold_through_ack();
    vec_cnt++; if (both_cnt !== 0) begin miss_cnt++; $display("FAIL strobe_overlap got %0d exp 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "bench timeout");
  end

endmodule : tb_ram_arbiter
